prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 22 ++
 rtl/prog_loader_if.sv | 32 +++
 rtl/prog_loader_byte_fifo.sv | 47 ++++
 rtl/prog_loader.sv | 126 ++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared constants and state type for the program loader
package prog_loader_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LEN  = ST_LEN,
        S_LOAD = ST_LOAD,
        S_CSUM = ST_CSUM,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and instruction-memory write bus
interface prog_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       mem_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        input  mem_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        output mem_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/prog_loader_byte_fifo.sv
// rtl/prog_loader_byte_fifo.sv - registered byte FIFO with flush and visible head
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    // Pointer update; flush and reset both empty the buffer
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program into instruction memory (PROG_LOADER_CSUM_EN adds trailing checksum)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    prog_loader_if.slave       bus,
    output logic               cpu_rst_n,
    output logic               done,
    output logic               err
);

    logic [2:0] state;
    logic [7:0] count;
    logic [7:0] len_m1;

    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       fifo_push;
    logic       fifo_pop;

    logic       in_rx;
    logic       start_ok;
    logic       wr;

    assign in_rx    = (state == ST_LEN) || (state == ST_LOAD) || (state == ST_CSUM);
    assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
    assign wr       = (state == ST_LOAD) && !fifo_empty && bus.mem_ready;

    assign bus.s_ready   = in_rx && !fifo_full;
    assign fifo_push     = bus.s_valid && bus.s_ready;

    assign bus.mem_we    = wr;
    assign bus.mem_addr  = count;
    assign bus.mem_wdata = wr ? fifo_head : 8'h00;

    assign done      = (state == ST_DONE);
    assign cpu_rst_n = (state == ST_DONE);

`ifdef PROG_LOADER_CSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_final;

    assign csum_final = csum + fifo_head;
    assign fifo_pop   = ((state == ST_LEN) && !fifo_empty) || wr
                      || ((state == ST_CSUM) && !fifo_empty);
    assign err        = (state == ST_ERR);

    // Running sum over the length byte and every program byte written
    always_ff @(posedge clk) begin
        if (!rst || start_ok) begin
            csum <= 8'h00;
        end else if ((state == ST_LEN) && !fifo_empty) begin
            csum <= fifo_head;
        end else if (wr) begin
            csum <= csum + fifo_head;
        end
    end
`else
    assign fifo_pop = ((state == ST_LEN) && !fifo_empty) || wr;
    assign err      = 1'b0;
`endif

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (start_ok),
        .din   (bus.s_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Load sequencer; length byte is kept as N-1 so N=0 naturally means 256
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_IDLE;
            count  <= 8'h00;
            len_m1 <= 8'h00;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state <= ST_LEN;
                        count <= 8'h00;
                    end
                end
                ST_LEN: begin
                    if (!fifo_empty) begin
                        len_m1 <= fifo_head - 8'd1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (wr) begin
                        count <= count + 8'd1;
                        if (count == len_m1) begin
`ifdef PROG_LOADER_CSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                ST_CSUM: begin
                    if (!fifo_empty) begin
                        state <= (csum_final == 8'h00) ? ST_DONE : ST_ERR;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
